// File: rtl/audio_mem_pkg.sv
// Shared definitions for the dual-port audio sample RAM.
// Holds the read-during-write policy codes, the clear-sequencer state
// encoding and the default geometry used by the RAM and its interface.
package audio_mem_pkg;

  // Read-during-write policy for a same-address A write / B read
  localparam int RDW_OLD = 0;  // B sees the word as it was before the write
  localparam int RDW_NEW = 1;  // B sees the byte-merged word being written

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ADDRESS_WIDTH = 12;
  localparam int DEF_DEPTH         = 4096;
  localparam int DEF_BYTE_WIDTH    = 8;
  localparam int DEF_READ_LATENCY  = 1;

  // Clear sequencer: CLEAR owns the array after reset, READY serves ports
  typedef enum logic {
    SEQ_CLEAR = 1'b0,
    SEQ_READY = 1'b1
  } seq_state_e;

endpackage

// File: rtl/audio_ram_dp_if.sv
// Port bundle for audio_ram_dp.
// Port A: aEn/aWEn/aByteEn/aAddr/aDataIn requests, aDataOut/aValid returns.
// Port B: bEn/bAddr read requests, bDataOut/bValid returns.
// clearBusy reports that the clear sequencer currently owns the array.
// master = requester side (processor / playback path), slave = the RAM.
interface audio_ram_dp_if
  import audio_mem_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int BYTE_WIDTH    = DEF_BYTE_WIDTH
);
  localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;

  logic                     clearBusy;
  logic                     aEn;
  logic                     aWEn;
  logic [NUM_LANES-1:0]     aByteEn;
  logic [ADDRESS_WIDTH-1:0] aAddr;
  logic [DATA_WIDTH-1:0]    aDataIn;
  logic [DATA_WIDTH-1:0]    aDataOut;
  logic                     aValid;
  logic                     bEn;
  logic [ADDRESS_WIDTH-1:0] bAddr;
  logic [DATA_WIDTH-1:0]    bDataOut;
  logic                     bValid;

  modport master (
    output aEn, aWEn, aByteEn, aAddr, aDataIn, bEn, bAddr,
    input  clearBusy, aDataOut, aValid, bDataOut, bValid
  );

  modport slave (
    input  aEn, aWEn, aByteEn, aAddr, aDataIn, bEn, bAddr,
    output clearBusy, aDataOut, aValid, bDataOut, bValid
  );

endinterface

// File: rtl/audio_ram_dp_lane_merge.sv
// ram_lane_merge: combinational byte-lane merge.
// Ports: old_word (current array word), new_word (write data),
//        lane_en (one enable per BYTE_WIDTH lane), merged (result word).
// Lanes with lane_en set take new_word, the rest keep old_word.
module ram_lane_merge
  import audio_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]            old_word,
  input  logic [DATA_WIDTH-1:0]            new_word,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] lane_en,
  output logic [DATA_WIDTH-1:0]            merged
);
  localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;

  always_comb begin
    // NOTE: assigning the full output before the conditional lane overrides
    // keeps every path driven, so no latch is inferred.
    merged = old_word;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_en[i]) merged[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

endmodule

// File: rtl/audio_ram_dp.sv
// audio_ram_dp: dual-port sample/data RAM shared by the processor (port A,
// read/write with byte lanes) and the playback path (port B, read only).
// Ports: clk (falling-edge active), reset (sync, active-high), bus (slave
// modport of audio_ram_dp_if). After reset a sequencer zeroes every word
// while clearBusy is high; port requests are ignored until it finishes.
// Reads return after READ_LATENCY (1 or 2) edges with a one-cycle valid.
module audio_ram_dp
  import audio_mem_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int BYTE_WIDTH    = DEF_BYTE_WIDTH,
  parameter int READ_LATENCY  = DEF_READ_LATENCY,
  parameter int RDW_MODE      = RDW_OLD
) (
  input logic           clk,
  input logic           reset,
  audio_ram_dp_if.slave bus
);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  // ---------------------------------------------------------------- sequencer
  seq_state_e               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                     ready;

  always_ff @(negedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (reset) begin
      state_q   <= SEQ_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      SEQ_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) state_d = SEQ_READY;
      end
      default: ;
    endcase
  end

  assign ready         = (state_q == SEQ_READY);
  assign bus.clearBusy = ~ready;

  // ----------------------------------------------------------- request decode
  logic a_in_range, b_in_range, a_wr, a_rd, b_rd, collide;

  assign a_in_range = (32'(bus.aAddr) < DEPTH);
  assign b_in_range = (32'(bus.bAddr) < DEPTH);
  assign a_wr       = ready & bus.aEn & bus.aWEn & a_in_range;
  assign a_rd       = ready & bus.aEn & ~bus.aWEn;
  assign b_rd       = ready & bus.bEn;
  assign collide    = a_wr & (bus.aAddr == bus.bAddr);

  // -------------------------------------------------------------------- array
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] a_raw, a_merged, a_word, b_word;

  assign a_raw = mem[bus.aAddr];

  ram_lane_merge #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_merge (
    .old_word (a_raw),
    .new_word (bus.aDataIn),
    .lane_en  (bus.aByteEn),
    .merged   (a_merged)
  );

  // A collision can only hit when aAddr == bAddr, so the A-side merge result
  // doubles as the write-through value for port B.
  assign a_word = a_in_range ? a_raw : '0;
  assign b_word = !b_in_range                       ? '0       :
                  (RDW_MODE == RDW_NEW && collide)  ? a_merged :
                                                      mem[bus.bAddr];

  // NOTE: the array itself has no reset branch; zeroing is done one word per
  // edge by the sequencer, which keeps this mappable onto block RAM.
  always_ff @(negedge clk) begin
    if (!reset) begin
      if (!ready)    mem[clr_cnt_q] <= '0;
      else if (a_wr) mem[bus.aAddr] <= a_merged;
    end
  end

  // ----------------------------------------------------------- read pipelines
  logic [DATA_WIDTH-1:0] a_data_s1, b_data_s1;
  logic                  a_valid_s1, b_valid_s1;

  always_ff @(negedge clk) begin
    if (reset) begin
      a_data_s1  <= '0;
      b_data_s1  <= '0;
      a_valid_s1 <= 1'b0;
      b_valid_s1 <= 1'b0;
    end else begin
      a_valid_s1 <= a_rd;
      b_valid_s1 <= b_rd;
      if (a_rd) a_data_s1 <= a_word;
      if (b_rd) b_data_s1 <= b_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] a_data_s2, b_data_s2;
    logic                  a_valid_s2, b_valid_s2;

    always_ff @(negedge clk) begin
      if (reset) begin
        a_data_s2  <= '0;
        b_data_s2  <= '0;
        a_valid_s2 <= 1'b0;
        b_valid_s2 <= 1'b0;
      end else begin
        a_valid_s2 <= a_valid_s1;
        b_valid_s2 <= b_valid_s1;
        if (a_valid_s1) a_data_s2 <= a_data_s1;
        if (b_valid_s1) b_data_s2 <= b_data_s1;
      end
    end

    assign bus.aDataOut = a_data_s2;
    assign bus.aValid   = a_valid_s2;
    assign bus.bDataOut = b_data_s2;
    assign bus.bValid   = b_valid_s2;
  end else begin : g_lat1
    assign bus.aDataOut = a_data_s1;
    assign bus.aValid   = a_valid_s1;
    assign bus.bDataOut = b_data_s1;
    assign bus.bValid   = b_valid_s1;
  end

endmodule

// File: tb/tb_audio_ram_dp.sv
// Bench for audio_ram_dp. Two instances share one stimulus stream:
//   dut0: DEPTH=16, READ_LATENCY=1, RDW_MODE=old
//   dut1: DEPTH=12, READ_LATENCY=2, RDW_MODE=new (addresses 12..15 out of range)
// A reference word array per instance predicts read data; each expected read
// is queued with the cycle it must appear on and popped by the monitor.
module tb_audio_ram_dp;
  import audio_mem_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          a_en = 1'b0, a_we = 1'b0, b_en = 1'b0;
  logic [NL-1:0] a_be = '0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_din = '0;

  audio_ram_dp_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BYTE_WIDTH(8)) if0 ();
  audio_ram_dp_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BYTE_WIDTH(8)) if1 ();

  assign if0.aEn = a_en;  assign if0.aWEn = a_we;  assign if0.aByteEn = a_be;
  assign if0.aAddr = a_addr;  assign if0.aDataIn = a_din;
  assign if0.bEn = b_en;  assign if0.bAddr = b_addr;
  assign if1.aEn = a_en;  assign if1.aWEn = a_we;  assign if1.aByteEn = a_be;
  assign if1.aAddr = a_addr;  assign if1.aDataIn = a_din;
  assign if1.bEn = b_en;  assign if1.bAddr = b_addr;

  audio_ram_dp #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(16), .BYTE_WIDTH(8),
                 .READ_LATENCY(1), .RDW_MODE(RDW_OLD))
    dut0 (.clk(clk), .reset(reset), .bus(if0));
  audio_ram_dp #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(12), .BYTE_WIDTH(8),
                 .READ_LATENCY(2), .RDW_MODE(RDW_NEW))
    dut1 (.clk(clk), .reset(reset), .bus(if1));

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t qa0[$], qb0[$], qa1[$], qb1[$];
  logic [DW-1:0] mdl [2][16];

  int checks = 0;
  int errors = 0;
  int cyc = 0;      // falling edges seen
  int esr = 0;      // non-reset falling edges since the last reset edge
  bit started = 1'b0;

  function automatic int depth_of(int d); return (d == 0) ? 16 : 12; endfunction
  function automatic int lat_of(int d);   return (d == 0) ? 1 : 2;   endfunction
  function automatic bit rdw_new(int d);  return (d == 1);           endfunction

  function automatic logic [DW-1:0] merge_m(logic [DW-1:0] o, logic [DW-1:0] n, logic [NL-1:0] en);
    logic [DW-1:0] mask;
    mask = '0;
    for (int i = 0; i < NL; i++) if (en[i]) mask[i*8 +: 8] = 8'hFF;
    return (o & ~mask) | (n & mask);
  endfunction

  function automatic void push(int d, bit port_b, logic [DW-1:0] data);
    exp_t e;
    e.data = data;
    e.due  = cyc + lat_of(d);
    case ({d[0], port_b})
      2'b00:   qa0.push_back(e);
      2'b01:   qb0.push_back(e);
      2'b10:   qa1.push_back(e);
      default: qb1.push_back(e);
    endcase
  endfunction

  task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    esr = reset ? 0 : esr + 1;
  end

  // Output monitor: exact clearBusy timing, valid on the predicted cycle only,
  // and read data against the scoreboard.
  always @(posedge clk) begin
    if (started) begin : mon
      bit ev;
      check("busy0", DW'(if0.clearBusy), DW'(esr < 16));
      check("busy1", DW'(if1.clearBusy), DW'(esr < 12));

      ev = (qa0.size() > 0) && (qa0[0].due == cyc);
      check("a0_valid", DW'(if0.aValid), DW'(ev));
      if (ev) begin check("a0_data", if0.aDataOut, qa0[0].data); void'(qa0.pop_front()); end

      ev = (qb0.size() > 0) && (qb0[0].due == cyc);
      check("b0_valid", DW'(if0.bValid), DW'(ev));
      if (ev) begin check("b0_data", if0.bDataOut, qb0[0].data); void'(qb0.pop_front()); end

      ev = (qa1.size() > 0) && (qa1[0].due == cyc);
      check("a1_valid", DW'(if1.aValid), DW'(ev));
      if (ev) begin check("a1_data", if1.aDataOut, qa1[0].data); void'(qa1.pop_front()); end

      ev = (qb1.size() > 0) && (qb1[0].due == cyc);
      check("b1_valid", DW'(if1.bValid), DW'(ev));
      if (ev) begin check("b1_data", if1.bDataOut, qb1[0].data); void'(qb1.pop_front()); end
    end
  end

  // One clock of stimulus: predict both instances, drive, advance to the next
  // rising edge (inputs then stay stable across the active falling edge).
  task automatic step(bit rst, bit ae, bit awe, logic [NL-1:0] lanes, logic [AW-1:0] aa,
                      logic [DW-1:0] ad, bit bre, logic [AW-1:0] ba);
    for (int d = 0; d < 2; d++) begin
      bit busy, a_ok, b_ok;
      logic [DW-1:0] bval;
      busy = rst || (esr < depth_of(d));
      a_ok = (int'(aa) < depth_of(d));
      b_ok = (int'(ba) < depth_of(d));
      if (busy) begin
        for (int w = 0; w < 16; w++) mdl[d][w] = '0;
      end else begin
        if (bre) begin
          bval = b_ok ? mdl[d][ba] : '0;
          if (rdw_new(d) && ae && awe && a_ok && aa == ba) bval = merge_m(mdl[d][aa], ad, lanes);
          push(d, 1'b1, bval);
        end
        if (ae && !awe) push(d, 1'b0, a_ok ? mdl[d][aa] : '0);
        if (ae && awe && a_ok) mdl[d][aa] = merge_m(mdl[d][aa], ad, lanes);
      end
    end
    reset = rst;  a_en = ae;  a_we = awe;  a_be = lanes;
    a_addr = aa;  a_din = ad;  b_en = bre;  b_addr = ba;
    @(posedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask
  task automatic wr(logic [AW-1:0] a, logic [DW-1:0] v, logic [NL-1:0] lanes);
    step(1'b0, 1'b1, 1'b1, lanes, a, v, 1'b0, '0);
  endtask
  task automatic brd(logic [AW-1:0] a);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, a);
  endtask
  task automatic ard(logic [AW-1:0] a);
    step(1'b0, 1'b1, 1'b0, '0, a, '0, 1'b0, '0);
  endtask

  initial begin
    // Reset: outputs cleared, sequencer busy
    repeat (4) step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    started = 1'b1;
    check("rst_a0_data", if0.aDataOut, '0);
    check("rst_b0_data", if0.bDataOut, '0);
    check("rst_b1_data", if1.bDataOut, '0);
    check("rst_a1_valid", DW'(if1.aValid), '0);
    check("rst_busy0", DW'(if0.clearBusy), DW'(1));
    check("rst_busy1", DW'(if1.clearBusy), DW'(1));

    // Requests during CLEAR must be ignored, then wait out the clear
    step(1'b0, 1'b1, 1'b1, 4'hF, 4'd3, 32'hFFFF_FFFF, 1'b1, 4'd3);
    idle(17);

    // Everything reads zero (dut1 12..15 are out of range -> 0 with valid)
    for (int i = 0; i < 16; i++) brd(AW'(i));
    idle(3);

    // Byte-lane merge
    wr(4'd5, 32'hDEAD_BEEF, 4'b1111);
    wr(4'd5, 32'h0000_1100, 4'b0010);
    brd(4'd5);
    idle(3);

    // Read-during-write collision, then the follow-up read
    wr(4'd7, 32'hAAAA_AAAA, 4'b1111);
    step(1'b0, 1'b1, 1'b1, 4'b1111, 4'd7, 32'h1234_5678, 1'b1, 4'd7);
    brd(4'd7);
    idle(3);

    // Zero lane enables is a no-op write; read back through port A
    wr(4'd5, 32'hFFFF_FFFF, 4'b0000);
    ard(4'd5);
    idle(3);

    // Out-of-range write on dut1 is dropped, neighbours untouched
    wr(4'd11, 32'h0B0B_0B0B, 4'b1111);
    wr(4'd13, 32'h5555_5555, 4'b1111);
    brd(4'd13);
    brd(4'd11);
    brd(4'd1);
    ard(4'd13);
    idle(3);

    // Streaming on both ports every edge
    for (int i = 0; i < 16; i++) wr(AW'(i), DW'(i * 3), 4'b1111);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, '0, AW'(i), '0, 1'b1, AW'(i));
    idle(3);

    // Reset in the middle of a clear restarts the counter
    repeat (2) step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    idle(8);
    repeat (2) step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    idle(17);
    for (int i = 0; i < 16; i++) brd(AW'(i));
    idle(4);

    check("qa0_drained", DW'(qa0.size()), '0);
    check("qb0_drained", DW'(qb0.size()), '0);
    check("qa1_drained", DW'(qa1.size()), '0);
    check("qb1_drained", DW'(qb1.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_ram_dp.md
# audio_ram_dp

Parametrised dual-port sample/data RAM: one read/write port (A) and one read-only port (B), with byte-lane write enables, configurable read latency and read-during-write policy, and a hardware clear sequencer that zeroes the array after reset. It replaces the single-port word RAM as the shared buffer between the processor data path (port A) and the audio playback/mixing path (port B).

## Interface
- `DATA_WIDTH`, 32: word width; must be a multiple of `BYTE_WIDTH`.
- `ADDRESS_WIDTH`, 12: address bits on both ports.
- `DEPTH`, 4096: number of words; `DEPTH <= 2**ADDRESS_WIDTH`.
- `BYTE_WIDTH`, 8: bits per write-enable lane; `NUM_LANES = DATA_WIDTH/BYTE_WIDTH`.
- `READ_LATENCY`, 1: 1 or 2 clock edges from request to data.
- `RDW_MODE`, 0: same-address collision where A writes and B reads on the same edge. 0 = B returns old word; 1 = B returns new (byte-merged) word.
---
- `clk`  in  1  clock; all state changes on the falling edge.
- `reset`  in  1  synchronous, active-high; sampled on the active (falling) edge of `clk`.
- `clearBusy`  out  1  high while the clear sequencer owns the array.
- `aEn`  in  1  port A request.
- `aWEn`  in  1  with `aEn`: 1 = write, 0 = read.
- `aByteEn`  in  NUM_LANES  write lane enables; ignored on reads.
- `aAddr`  in  ADDRESS_WIDTH  port A address.
- `aDataIn`  in  DATA_WIDTH  write data.
- `aDataOut`  out  DATA_WIDTH  port A read data.
- `aValid`  out  1  one-cycle pulse: `aDataOut` updated by a read.
- `bEn`  in  1  port B read request.
- `bAddr`  in  ADDRESS_WIDTH  port B address.
- `bDataOut`  out  DATA_WIDTH  port B read data.
- `bValid`  out  1  one-cycle pulse: `bDataOut` updated.

## Operation
- Reset: `aDataOut`, `bDataOut`, `aValid`, `bValid` = 0, all pipeline stages cleared; `clearBusy` = 1; sequencer enters CLEAR with counter = 0.
- Sequencer states: CLEAR, READY.
  - CLEAR: each non-reset edge writes 0 to word[counter], counter+1; on the edge writing `DEPTH-1`, go to READY and drop `clearBusy`. Port requests are ignored (no write, no valid).
  - READY: normal operation. Never returns to CLEAR except via `reset`.
  - `reset` during CLEAR restarts the counter at 0.
- Port A write: for each lane i with `aByteEn[i]`, word[aAddr] lane i <= aDataIn lane i; other lanes unchanged. `aByteEn` = 0 is a legal no-op. `aDataOut` holds its previous value; no `aValid`.
- Port A read / port B read: word at address returned after `READ_LATENCY` edges with the matching valid pulse. Data outputs hold between reads.
- Collision (A write, B read, same address, same edge): result follows `RDW_MODE`. An A read never collides with its own port.
- Out-of-range address (`>= DEPTH`): writes dropped, reads return 0 with valid asserted.
- Back-to-back requests on every edge are accepted on both ports; no stall, no backpressure.

## Timing
- `READ_LATENCY`=1: request sampled on edge N; data and valid are registered on edge N, visible until edge N+1.
- `READ_LATENCY`=2: one extra output register; data/valid visible after edge N+1.
- Clear: `clearBusy` low after exactly `DEPTH` falling edges following the last edge with `reset` high.
- Valid pulses are one cycle wide per request; consecutive requests produce consecutive pulses.

## Structure
- Shared package `audio_mem_pkg`: `RDW_OLD`/`RDW_NEW` constants, sequencer state enum, default width/depth constants.
- One sub-module `ram_lane_merge`: combinational byte-enable merge used by the write path and by `RDW_MODE`=1 bypass.
- Array, sequencer, and per-port read pipelines live in the top module.

## Test plan
- Reset for 3 cycles, release, DEPTH=16: `clearBusy` high for exactly 16 edges; then B reads of 0..15 all return 0x00000000.
- A write 0xDEADBEEF to 5 with `aByteEn`=1111, then `aByteEn`=0010 with 0x00001100: B read of 5 returns 0xDEAD11EF, `bValid` one cycle after request (latency 1), two (latency 2).
- Same-edge A write 0x12345678 / B read to address 7 holding 0xAAAAAAAA: `RDW_MODE`=0 returns 0xAAAAAAAA, `RDW_MODE`=1 returns 0x12345678; next B read returns 0x12345678 in both modes.
- Assert `reset` after 8 clear edges (DEPTH=16) with prior data written: counter restarts; `clearBusy` held 16 more edges; all words read 0.
- DEPTH=12, ADDRESS_WIDTH=4: A write to 13 then B read of 13 returns 0 with `bValid`; word 12-1=11 unchanged.
- Port A and B read on every edge across 0..15 after writing `addr*3`: outputs stream `addr*3` with continuous valid pulses, no gaps.
